voice_allocator: RTL and testbench

Sequential voice allocator between the PS/2 key-event decoder and the three tone generators. Accepts note-on/note-off events over a valid/ready handshake and assigns each note to one of three voices: free voices first, then voices in release, then the oldest held note. Drives per-voice gate, pitch ticks and owning scan code, and holds each released voice for a release window so the envelope can finish before reuse.

---
 rtl/voice_allocator.sv | 183 ++++++++++++++++++
 tb/tb_voice_allocator.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/voice_allocator.sv
// voice_allocator: maps note-on/note-off key events onto three tone-generator voices.
// Latency: voice outputs and steal update on the COMMIT edge, two edges after the handshake edge.
// Backpressure: ev_ready is low during SEARCH and COMMIT, so at most one event is accepted every 3 cycles.
module voice_allocator #(
  parameter logic [23:0] RELEASE_CYCLES = 24'd10_000_000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ev_valid,
  output logic        ev_ready,
  input  logic        ev_release,
  input  logic [7:0]  ev_code,
  input  logic [23:0] ev_ticks,
  output logic [2:0]  gate,
  output logic [2:0]  busy,
  output logic [23:0] ticks0,
  output logic [23:0] ticks1,
  output logic [23:0] ticks2,
  output logic [7:0]  code0,
  output logic [7:0]  code1,
  output logic [7:0]  code2,
  output logic [1:0]  voice_count,
  output logic        steal
);

  typedef enum logic [1:0] {S_IDLE, S_SEARCH, S_COMMIT} ctl_t;
  typedef enum logic [1:0] {V_FREE, V_HELD, V_REL} vst_t;
  typedef enum logic [1:0] {A_NONE, A_ON, A_OFF} act_t;

  ctl_t        r_state, w_state_nxt;
  vst_t        r_vst   [3];
  vst_t        w_vst_nxt [3];
  logic [23:0] r_cnt   [3];
  logic [23:0] r_ticks [3];
  logic [7:0]  r_code  [3];
  logic [1:0]  r_rank  [3];
  logic        r_ev_rel;
  logic [7:0]  r_ev_code;
  logic [23:0] r_ev_ticks;
  act_t        r_act, w_act;
  logic [1:0]  r_tgt, w_tgt;
  logic        r_retrig, w_retrig;
  logic        r_steal;
  logic [1:0]  r_vcount;
  logic [2:0]  w_gate_nxt;
  logic        w_commit;
  logic        w_hit, w_free, w_rel;
  logic [1:0]  w_hit_i, w_free_i, w_rel_i, w_old_i;

  assign w_commit = (r_state == S_COMMIT);

  // Controller state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  // Controller next state; ready only while idle.
  always_comb begin
    w_state_nxt = r_state;
    ev_ready    = 1'b0;
    case (r_state)
      S_IDLE: begin
        ev_ready = 1'b1;
        if (ev_valid) w_state_nxt = S_SEARCH;
      end
      S_SEARCH: w_state_nxt = S_COMMIT;
      S_COMMIT: w_state_nxt = S_IDLE;
      default:  w_state_nxt = S_IDLE;
    endcase
  end

  // Target search: owner match first, then lowest free, then oldest releasing, then oldest held.
  always_comb begin
    w_hit = 1'b0;  w_hit_i  = 2'd0;
    w_free = 1'b0; w_free_i = 2'd0;
    w_rel = 1'b0;  w_rel_i  = 2'd0;
    w_old_i  = 2'd0;
    w_act    = A_NONE;
    w_tgt    = 2'd0;
    w_retrig = 1'b0;
    for (int i = 0; i < 3; i++) begin
      if (r_vst[i] != V_FREE && r_code[i] == r_ev_code && !w_hit) begin
        w_hit = 1'b1; w_hit_i = 2'(i);
      end
      if (r_vst[i] == V_FREE && !w_free) begin
        w_free = 1'b1; w_free_i = 2'(i);
      end
      if (r_vst[i] == V_REL && (!w_rel || r_rank[i] > r_rank[w_rel_i])) begin
        w_rel = 1'b1; w_rel_i = 2'(i);
      end
      if (r_rank[i] == 2'd2) w_old_i = 2'(i);
    end
    if (r_ev_rel) begin
      // Note-off only acts on a held owner; a code already releasing is ignored.
      if (w_hit && r_vst[w_hit_i] == V_HELD) begin
        w_act = A_OFF; w_tgt = w_hit_i;
      end
    end else if (r_ev_ticks != 24'd0) begin
      w_act = A_ON;
      if (w_hit) begin
        w_tgt = w_hit_i; w_retrig = 1'b1;
      end else if (w_free) w_tgt = w_free_i;
      else if (w_rel)      w_tgt = w_rel_i;
      else                 w_tgt = w_old_i;
    end
  end

  // Event latch at the handshake and search result capture.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ev_rel <= 1'b0; r_ev_code <= 8'd0; r_ev_ticks <= 24'd0;
      r_act <= A_NONE; r_tgt <= 2'd0; r_retrig <= 1'b0;
    end else begin
      if (r_state == S_IDLE && ev_valid) begin
        r_ev_rel <= ev_release; r_ev_code <= ev_code; r_ev_ticks <= ev_ticks;
      end
      if (r_state == S_SEARCH) begin
        r_act <= w_act; r_tgt <= w_tgt; r_retrig <= w_retrig;
      end
    end
  end

  // Per-voice next state; a commit beats the release counter expiring on the same edge.
  always_comb begin
    for (int i = 0; i < 3; i++) begin
      w_vst_nxt[i] = r_vst[i];
      if (w_commit && r_act == A_ON && r_tgt == 2'(i))       w_vst_nxt[i] = V_HELD;
      else if (w_commit && r_act == A_OFF && r_tgt == 2'(i)) w_vst_nxt[i] = V_REL;
      else if (r_vst[i] == V_REL && r_cnt[i] == 24'd0)       w_vst_nxt[i] = V_FREE;
      w_gate_nxt[i] = (w_vst_nxt[i] == V_HELD);
    end
  end

  // Voice registers, release counters, age ranks, steal pulse and voice count.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 3; i++) begin
        r_vst[i]   <= V_FREE;
        r_cnt[i]   <= 24'd0;
        r_ticks[i] <= 24'd0;
        r_code[i]  <= 8'd0;
        r_rank[i]  <= 2'(2 - i);
      end
      r_steal  <= 1'b0;
      r_vcount <= 2'd0;
    end else begin
      r_steal  <= w_commit && r_act == A_ON && !r_retrig && r_vst[r_tgt] != V_FREE;
      r_vcount <= {1'b0, w_gate_nxt[0]} + {1'b0, w_gate_nxt[1]} + {1'b0, w_gate_nxt[2]};
      for (int i = 0; i < 3; i++) begin
        r_vst[i] <= w_vst_nxt[i];
        if (w_commit && r_act == A_ON && r_tgt == 2'(i)) begin
          r_ticks[i] <= r_ev_ticks;
          r_code[i]  <= r_ev_code;
        end
        if (w_commit && r_act == A_OFF && r_tgt == 2'(i)) r_cnt[i] <= RELEASE_CYCLES - 24'd1;
        else if (r_vst[i] == V_REL && r_cnt[i] != 24'd0)  r_cnt[i] <= r_cnt[i] - 24'd1;
        if (w_commit && r_act == A_ON) begin
          if (r_tgt == 2'(i))                  r_rank[i] <= 2'd0;
          else if (r_rank[i] < r_rank[r_tgt])  r_rank[i] <= r_rank[i] + 2'd1;
        end
      end
    end
  end

  // Output decode of the voice registers.
  always_comb begin
    for (int i = 0; i < 3; i++) begin
      gate[i] = (r_vst[i] == V_HELD);
      busy[i] = (r_vst[i] != V_FREE);
    end
  end

  assign ticks0      = r_ticks[0];
  assign ticks1      = r_ticks[1];
  assign ticks2      = r_ticks[2];
  assign code0       = r_code[0];
  assign code1       = r_code[1];
  assign code2       = r_code[2];
  assign voice_count = r_vcount;
  assign steal       = r_steal;

endmodule

// File: tb/tb_voice_allocator.sv
// Bench for voice_allocator: scoreboard of expected post-commit voice state,
// plus per-cycle gate/busy/steal tracking from an age-stamp model.
// Runs with a short release window so release timing is observable.
module tb_voice_allocator;

  localparam int REL_C = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        ev_valid, ev_ready, ev_release;
  logic [7:0]  ev_code;
  logic [23:0] ev_ticks;
  logic [2:0]  gate, busy;
  logic [23:0] ticks0, ticks1, ticks2;
  logic [7:0]  code0, code1, code2;
  logic [1:0]  voice_count;
  logic        steal;

  voice_allocator #(.RELEASE_CYCLES(24'(REL_C))) dut (
    .clk(clk), .rst(rst), .ev_valid(ev_valid), .ev_ready(ev_ready),
    .ev_release(ev_release), .ev_code(ev_code), .ev_ticks(ev_ticks),
    .gate(gate), .busy(busy), .ticks0(ticks0), .ticks1(ticks1), .ticks2(ticks2),
    .code0(code0), .code1(code1), .code2(code2), .voice_count(voice_count), .steal(steal)
  );

  always #5 clk = ~clk;

  int edge_cnt = 0;
  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  int n_checks = 0;
  int n_fail   = 0;
  bit mon_en   = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Reference model: voices ordered by allocation stamp (smaller = older).
  bit          m_held    [3];
  int          m_free_at [3];
  logic [7:0]  m_code    [3];
  logic [23:0] m_ticks   [3];
  int          m_stamp   [3];
  int          m_seq;

  typedef struct {
    int          due;
    logic [2:0]  gate;
    logic [2:0]  busy;
    logic [23:0] t0, t1, t2;
    logic [7:0]  c0, c1, c2;
    logic [1:0]  cnt;
    logic        stl;
  } exp_t;
  exp_t sb[$];

  function automatic void model_reset();
    for (int i = 0; i < 3; i++) begin
      m_held[i] = 1'b0; m_free_at[i] = 0; m_code[i] = 8'd0; m_ticks[i] = 24'd0; m_stamp[i] = i;
    end
    m_seq = 3;
  endfunction

  // Busy as seen after edge k.
  function automatic bit busy_at(int i, int k);
    return m_held[i] || (k < m_free_at[i]);
  endfunction

  // Event handshaken at edge n; results appear after commit edge n+2.
  function automatic void model_event(int n, bit rel, logic [7:0] code, logic [23:0] tk);
    int   c   = n + 2;
    int   t   = -1;
    int   hc  = 0;
    bit   hit = 1'b0;
    bit   stl = 1'b0;
    exp_t e;
    for (int i = 0; i < 3; i++) if (t < 0 && busy_at(i, n) && m_code[i] == code) t = i;
    if (rel) begin
      if (t >= 0 && m_held[t]) begin
        m_held[t] = 1'b0; m_free_at[t] = c + REL_C;
      end
    end else if (tk != 24'd0) begin
      if (t >= 0) hit = 1'b1;
      else begin
        for (int i = 0; i < 3; i++) if (t < 0 && !busy_at(i, n)) t = i;
        if (t < 0) for (int i = 0; i < 3; i++)
          if (!m_held[i] && (t < 0 || m_stamp[i] < m_stamp[t])) t = i;
        if (t < 0) for (int i = 0; i < 3; i++)
          if (t < 0 || m_stamp[i] < m_stamp[t]) t = i;
      end
      stl = !hit && busy_at(t, c - 1);
      m_held[t] = 1'b1; m_code[t] = code; m_ticks[t] = tk; m_stamp[t] = m_seq; m_seq++;
    end
    e.due = c;
    for (int i = 0; i < 3; i++) begin
      e.gate[i] = m_held[i];
      e.busy[i] = busy_at(i, c);
      if (m_held[i]) hc++;
    end
    e.t0 = m_ticks[0]; e.t1 = m_ticks[1]; e.t2 = m_ticks[2];
    e.c0 = m_code[0];  e.c1 = m_code[1];  e.c2 = m_code[2];
    e.cnt = 2'(hc);
    e.stl = stl;
    sb.push_back(e);
  endfunction

  // Output monitor: full compare at each commit, gate/busy/steal tracking otherwise.
  always @(negedge clk) begin
    exp_t e;
    logic [2:0] eg, eb;
    int hc;
    if (!rst && mon_en) begin
      if (sb.size() > 0 && sb[0].due == edge_cnt) begin
        e = sb.pop_front();
        check("gate", gate, e.gate);
        check("busy", busy, e.busy);
        check("ticks0", ticks0, e.t0);
        check("ticks1", ticks1, e.t1);
        check("ticks2", ticks2, e.t2);
        check("code0", code0, e.c0);
        check("code1", code1, e.c1);
        check("code2", code2, e.c2);
        check("voice_count", voice_count, e.cnt);
        check("steal", steal, e.stl);
        check("ready_after_commit", ev_ready, 1);
      end else begin
        check("steal_idle", steal, 0);
        if (sb.size() == 0) begin
          hc = 0;
          for (int i = 0; i < 3; i++) begin
            eg[i] = m_held[i];
            eb[i] = busy_at(i, edge_cnt);
            if (m_held[i]) hc++;
          end
          check("gate_track", gate, eg);
          check("busy_track", busy, eb);
          check("count_track", voice_count, hc);
        end
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send(input bit rel, input logic [7:0] code, input logic [23:0] tk);
    int w = 0;
    @(negedge clk);
    while (!ev_ready && w < 20) begin
      @(negedge clk);
      w++;
    end
    check("ready_wait", ev_ready, 1);
    ev_valid = 1'b1; ev_release = rel; ev_code = code; ev_ticks = tk;
    model_event(edge_cnt + 1, rel, code, tk);
    @(negedge clk);
    ev_valid = 1'b0; ev_release = 1'($urandom); ev_code = 8'($urandom); ev_ticks = 24'($urandom);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    sb.delete();
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  logic [7:0] pool [5] = '{8'h1C, 8'h1B, 8'h23, 8'h2B, 8'h34};
  int rel_cycles;

  initial begin
    rst = 1'b1; ev_valid = 1'b0; ev_release = 1'b0; ev_code = 8'd0; ev_ticks = 24'd0;
    model_reset();
    #23;
    check("rst_gate", gate, 0);
    check("rst_busy", busy, 0);
    check("rst_count", voice_count, 0);
    check("rst_steal", steal, 0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("ready_after_rst", ev_ready, 1);
    mon_en = 1'b1;

    // Fill three voices.
    send(0, 8'h1C, 24'd1493);
    send(0, 8'h1B, 24'd1330);
    send(0, 8'h23, 24'd1185);
    idle(3);
    check("fill_gate", gate, 3'b111);
    check("fill_t0", ticks0, 1493);
    check("fill_t1", ticks1, 1330);
    check("fill_t2", ticks2, 1185);
    check("fill_count", voice_count, 3);

    // Steal oldest twice.
    send(0, 8'h2B, 24'd1119);
    idle(3);
    check("steal_c0", code0, 8'h2B);
    check("steal_t0", ticks0, 1119);
    check("keep_c1", code1, 8'h1B);
    check("keep_c2", code2, 8'h23);
    send(0, 8'h34, 24'd996);
    idle(3);
    check("steal2_c1", code1, 8'h34);

    // Edge events: retrigger, zero ticks, off for an unheld code.
    send(0, 8'h23, 24'd1200);
    send(0, 8'h55, 24'd0);
    send(1, 8'h66, 24'd0);
    idle(3);
    check("retrig_t2", ticks2, 1200);
    check("retrig_gate", gate, 3'b111);

    // Release window length and reuse.
    do_reset();
    send(0, 8'h1C, 24'd1493);
    send(1, 8'h1C, 24'd0);
    rel_cycles = 0;
    for (int k = 0; k < 14; k++) begin
      @(negedge clk);
      if (busy[0] && !gate[0]) rel_cycles++;
    end
    check("release_window", rel_cycles, REL_C);
    send(0, 8'h1C, 24'd1493);
    send(1, 8'h1C, 24'd0);
    send(0, 8'h1D, 24'd1409);
    idle(8);
    check("reuse_c1", code1, 8'h1D);
    check("reuse_gate", gate, 3'b010);

    // Releasing voice preferred over held ones.
    do_reset();
    send(0, 8'h1C, 24'd1493);
    send(0, 8'h1B, 24'd1330);
    send(0, 8'h23, 24'd1185);
    send(1, 8'h1B, 24'd0);
    send(0, 8'h3B, 24'd791);
    idle(3);
    check("relpref_c1", code1, 8'h3B);
    check("relpref_gate", gate, 3'b111);

    // Reset between handshake and commit drops the event.
    send(0, 8'h44, 24'd500);
    #2;
    rst = 1'b1;
    #1;
    check("midrst_gate", gate, 0);
    check("midrst_busy", busy, 0);
    check("midrst_t0", ticks0, 0);
    check("midrst_c1", code1, 0);
    check("midrst_count", voice_count, 0);
    check("midrst_steal", steal, 0);
    sb.delete();
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("midrst_ready", ev_ready, 1);
    idle(4);
    check("dropped_gate", gate, 0);
    check("dropped_c0", code0, 0);

    // Random traffic with varied gaps to exercise release/commit races.
    for (int k = 0; k < 60; k++) begin
      send(($urandom_range(0, 9) < 4), pool[$urandom_range(0, 4)],
           ($urandom_range(0, 9) == 0) ? 24'd0 : 24'($urandom_range(1, 4000)));
      idle($urandom_range(0, 5));
    end

    for (int k = 0; k < 50 && sb.size() > 0; k++) @(negedge clk);
    check("sb_drained", sb.size(), 0);
    idle(10);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
